mem_port_arbiter: RTL and testbench

Shares the single sram-like memory port between the instruction-fetch requester and the EXE-stage data requester. Each request is granted in one cycle, and a request that is not accepted immediately is held stable at the memory port until it is. Accepted transactions are tracked in issue order so that each response is routed back to its owner. Responses to instruction fetches cancelled by a pipeline flush are dropped. The block sits between the IF/EXE stages and the memory bridge.

---
 rtl/mem_port_arbiter_pkg.sv | 22 ++
 rtl/arb_tracker_fifo.sv | 63 ++++++
 rtl/mem_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared owner codes, size encodings and grant-FSM types for mem_port_arbiter.
// Size encodings on the memory port: 0 = byte, 1 = half, 2 = word.
package mem_port_arbiter_pkg;

   localparam logic       ARB_OWNER_INST = 1'b0;
   localparam logic       ARB_OWNER_DATA = 1'b1;
   localparam logic [1:0] SIZE_WORD      = 2'd2;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_t;

   typedef struct packed {
      logic        wr;
      logic [1:0]  size;
      logic [3:0]  wstrb;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_cmd_t;

endpackage

// File: rtl/arb_tracker_fifo.sv
// In-order tracker of accepted memory transactions: one {owner, discard} entry per
// outstanding request; flush_inst marks every instruction entry as discarded.
module arb_tracker_fifo
   import mem_port_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic push,
   input  logic push_owner,
   input  logic push_discard,
   input  logic pop,
   input  logic flush_inst,
   output logic head_owner,
   output logic head_discard,
   output logic full,
   output logic empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0] r_owner;
   logic [DEPTH-1:0] r_discard;
   logic [PW-1:0]    r_rd_ptr;
   logic [PW-1:0]    r_wr_ptr;
   logic [CW-1:0]    r_count;
   logic [PW-1:0]    w_rd_next;
   logic [PW-1:0]    w_wr_next;

   assign w_rd_next    = (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
   assign w_wr_next    = (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
   assign full         = (r_count == CW'(DEPTH));
   assign empty        = (r_count == '0);
   assign head_owner   = r_owner[r_rd_ptr];
   assign head_discard = r_discard[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (push) r_wr_ptr <= w_wr_next;
         if (pop)  r_rd_ptr <= w_rd_next;
         if (push && !pop)      r_count <= r_count + CW'(1);
         else if (pop && !push) r_count <= r_count - CW'(1);
      end
   end

   // NOTE: entry storage has no reset; only slots between the pointers are ever read.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (flush_inst && r_owner[i] == ARB_OWNER_INST) r_discard[i] <= 1'b1;
      end
      if (push) begin
         r_owner[r_wr_ptr]   <= push_owner;
         r_discard[r_wr_ptr] <= push_discard;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one sram-like memory port between instruction fetch and EXE data requests.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise DATA has fixed priority.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [1:0]  mem_size,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata
);

   arb_state_t r_state;
   arb_state_t w_next_state;
   mem_cmd_t   r_cmd;
   mem_cmd_t   w_cmd;
   logic       r_owner;
   logic       r_lock_discard;
   logic       w_sel_data;
   logic       w_owner;
   logic       w_locked;
   logic       w_mem_req;
   logic       w_accept;
   logic       w_pop;
   logic       w_push_discard;
   logic       w_full;
   logic       w_empty;
   logic       w_head_owner;
   logic       w_head_discard;

`ifdef MEM_ARB_RR_EN
   logic r_last_owner;

   always_ff @(posedge clk) begin
      if (reset)         r_last_owner <= ARB_OWNER_DATA;
      else if (w_accept) r_last_owner <= w_owner;
   end

   assign w_sel_data = data_req & (~inst_req | (r_last_owner == ARB_OWNER_INST));
`else
   assign w_sel_data = data_req;
`endif

   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:   if (w_mem_req && !mem_addr_ok) w_next_state = ST_LOCKED;
         ST_LOCKED: if (mem_addr_ok) w_next_state = ST_IDLE;
         default:   w_next_state = ST_IDLE;
      endcase
   end

   // NOTE: every signal gets a value on every path here, so no latches are inferred.
   always_comb begin
      w_locked  = (r_state == ST_LOCKED);
      w_mem_req = ~reset & (w_locked | (~w_full & (inst_req | data_req)));
      if (w_locked) begin
         w_owner = r_owner;
         w_cmd   = r_cmd;
      end else if (w_sel_data) begin
         w_owner = ARB_OWNER_DATA;
         w_cmd   = '{wr: data_wr, size: data_size, wstrb: data_wstrb,
                     addr: data_addr, wdata: data_wdata};
      end else begin
         w_owner = ARB_OWNER_INST;
         w_cmd   = '{wr: 1'b0, size: SIZE_WORD, wstrb: 4'h0, addr: inst_addr, wdata: 32'h0};
      end
      if (!w_mem_req) w_cmd = '0;
   end

   // A request that enters LOCKED during a flush is already stale, so it is marked too.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_owner        <= ARB_OWNER_INST;
         r_cmd          <= '0;
         r_lock_discard <= 1'b0;
      end else if (r_state == ST_IDLE) begin
         if (w_mem_req && !mem_addr_ok) begin
            r_owner        <= w_owner;
            r_cmd          <= w_cmd;
            r_lock_discard <= flush & (w_owner == ARB_OWNER_INST);
         end
      end else if (mem_addr_ok) begin
         r_lock_discard <= 1'b0;
      end else if (flush && r_owner == ARB_OWNER_INST) begin
         r_lock_discard <= 1'b1;
      end
   end

   assign w_accept       = w_mem_req & mem_addr_ok;
   assign w_pop          = ~reset & mem_data_ok & ~w_empty;
   assign w_push_discard = (w_owner == ARB_OWNER_INST) & (flush | (w_locked & r_lock_discard));

   arb_tracker_fifo #(.DEPTH(OUTSTANDING)) u_tracker (
      .clk          (clk),
      .reset        (reset),
      .push         (w_accept),
      .push_owner   (w_owner),
      .push_discard (w_push_discard),
      .pop          (w_pop),
      .flush_inst   (flush),
      .head_owner   (w_head_owner),
      .head_discard (w_head_discard),
      .full         (w_full),
      .empty        (w_empty)
   );

   assign mem_req      = w_mem_req;
   assign mem_wr       = w_cmd.wr;
   assign mem_size     = w_cmd.size;
   assign mem_wstrb    = w_cmd.wstrb;
   assign mem_addr     = w_cmd.addr;
   assign mem_wdata    = w_cmd.wdata;

   assign inst_addr_ok = w_accept & (w_owner == ARB_OWNER_INST) & ~flush
                         & ~(w_locked & r_lock_discard);
   assign data_addr_ok = w_accept & (w_owner == ARB_OWNER_DATA);
   assign inst_data_ok = w_pop & (w_head_owner == ARB_OWNER_INST) & ~w_head_discard;
   assign data_data_ok = w_pop & (w_head_owner == ARB_OWNER_DATA);
   assign inst_rdata   = reset ? 32'h0 : mem_rdata;
   assign data_rdata   = reset ? 32'h0 : mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run
// compared against a queue-based transaction model. Honors MEM_ARB_RR_EN.
module tb_mem_port_arbiter;

   localparam int   OUTST    = 2;
   localparam logic OWN_INST = 1'b0;
   localparam logic OWN_DATA = 1'b1;
`ifdef MEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset, flush;
   logic        inst_req, inst_addr_ok, inst_data_ok;
   logic [31:0] inst_addr, inst_rdata;
   logic        data_req, data_wr, data_addr_ok, data_data_ok;
   logic [1:0]  data_size;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr, data_wdata, data_rdata;
   logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
   logic [1:0]  mem_size;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic own;
      logic disc;
   } ent_t;

   mem_port_arbiter #(.OUTSTANDING(OUTST)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [139:0] out_vec();
      return {mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
              inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, inst_rdata, data_rdata};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic clear_inputs();
      flush = 0; inst_req = 0; inst_addr = 0;
      data_req = 0; data_wr = 0; data_size = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
      mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1;
      tick();
      tick();
      reset = 0;
   endtask

   task automatic test_reset();
      reset = 1; inst_req = 1; inst_addr = 32'h1234_5678; data_req = 1; data_wr = 1;
      data_addr = 32'hCAFE_0000; data_wdata = 32'h5555_AAAA; data_wstrb = 4'hF;
      mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'hFFFF_FFFF; flush = 1;
      tick();
      settle();
      total++;
      if (out_vec() !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got %h want all zero", out_vec());
      end
      tick();
      do_reset();
   endtask

   task automatic test_lone_fetch();
      do_reset();
      inst_req = 1; inst_addr = 32'h1C00_0000; mem_addr_ok = 1;
      settle();
      total++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h1C00_0000 || inst_addr_ok !== 1'b1 ||
          mem_wr !== 1'b0 || mem_size !== 2'd2 || mem_wstrb !== 4'h0) begin
         bad++;
         $display("FAIL lone_req: req=%b addr=%h aok=%b wr=%b size=%0d want 1 1c000000 1 0 2",
                  mem_req, mem_addr, inst_addr_ok, mem_wr, mem_size);
      end
      tick();
      clear_inputs();
      tick();
      mem_data_ok = 1; mem_rdata = 32'hDEAD_BEEF;
      settle();
      total++;
      if (inst_data_ok !== 1'b1 || inst_rdata !== 32'hDEAD_BEEF || data_data_ok !== 1'b0) begin
         bad++;
         $display("FAIL lone_resp: inst_data_ok=%b rdata=%h data_data_ok=%b want 1 deadbeef 0",
                  inst_data_ok, inst_rdata, data_data_ok);
      end
      tick();
      clear_inputs();
   endtask

   task automatic test_contention();
      int ncyc;
      logic [1:0] want;
      do_reset();
      ncyc = RR ? 4 : 3;
      for (int c = 0; c < ncyc; c++) begin
         inst_req = 1; inst_addr = 32'h1C00_0000 + 32'(c * 4);
         data_req = RR ? 1'b1 : (c < 2);
         data_addr = 32'h8000_0100 + 32'(c * 4);
         mem_addr_ok = 1; mem_data_ok = (c > 0);
         if (RR) want = (c % 2 == 0) ? 2'b10 : 2'b01;
         else    want = (c < 2) ? 2'b01 : 2'b10;
         settle();
         total++;
         if ({inst_addr_ok, data_addr_ok} !== want) begin
            bad++;
            $display("FAIL contention_c%0d: {inst_aok,data_aok}=%b want %b",
                     c, {inst_addr_ok, data_addr_ok}, want);
         end
         tick();
      end
      do_reset();
   endtask

   task automatic test_lock();
      int pulses = 0;
      do_reset();
      for (int c = 0; c < 5; c++) begin
         data_req = (c < 4); data_wr = 1; data_size = 2'd2; data_wstrb = 4'hF;
         data_addr = (c == 0) ? 32'h8000_0004 : 32'h1234_5678;
         data_wdata = (c == 0) ? 32'hA5A5_0001 : 32'h0BAD_0BAD;
         inst_req = (c == 1); inst_addr = 32'h1C00_0040;
         mem_addr_ok = (c == 3);
         settle();
         if (data_addr_ok === 1'b1) pulses++;
         if (c < 4) begin
            total++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h8000_0004 || mem_wr !== 1'b1 ||
                mem_wstrb !== 4'hF || mem_wdata !== 32'hA5A5_0001 ||
                data_addr_ok !== (c == 3) || inst_addr_ok !== 1'b0) begin
               bad++;
               $display("FAIL lock_c%0d: req=%b addr=%h wr=%b wstrb=%h wdata=%h daok=%b iaok=%b want 1 80000004 1 f a5a50001 %b 0",
                        c, mem_req, mem_addr, mem_wr, mem_wstrb, mem_wdata,
                        data_addr_ok, inst_addr_ok, c == 3);
            end
         end
         tick();
      end
      total++;
      if (pulses != 1) begin
         bad++;
         $display("FAIL lock_pulses: data_addr_ok pulses=%0d want 1", pulses);
      end
      do_reset();
   endtask

   task automatic test_flush();
      do_reset();
      for (int c = 0; c < 2; c++) begin
         inst_req = 1; inst_addr = 32'h1C00_0000 + 32'(c * 4); mem_addr_ok = 1;
         tick();
      end
      clear_inputs();
      flush = 1;
      tick();
      flush = 0;
      for (int c = 0; c < 3; c++) begin
         mem_data_ok = 1; mem_rdata = 32'h7000_0000 + 32'(c);
         settle();
         total++;
         if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin
            bad++;
            $display("FAIL flush_resp%0d: inst_data_ok=%b data_data_ok=%b want 0 0",
                     c, inst_data_ok, data_data_ok);
         end
         tick();
      end
      clear_inputs();
      data_req = 1; data_addr = 32'h8000_0010; data_size = 2'd2; mem_addr_ok = 1;
      tick();
      clear_inputs();
      mem_data_ok = 1; mem_rdata = 32'h0123_4567;
      settle();
      total++;
      if (data_data_ok !== 1'b1 || data_rdata !== 32'h0123_4567 || inst_data_ok !== 1'b0) begin
         bad++;
         $display("FAIL flush_data_after: data_data_ok=%b rdata=%h inst_data_ok=%b want 1 01234567 0",
                  data_data_ok, data_rdata, inst_data_ok);
      end
      tick();
      clear_inputs();
   endtask

   task automatic test_full_and_reset();
      do_reset();
      inst_req = 1; inst_addr = 32'h1C00_0100; mem_addr_ok = 1;
      tick();
      inst_req = 0; data_req = 1; data_addr = 32'h8000_0200;
      tick();
      clear_inputs();
      inst_req = 1; inst_addr = 32'h1C00_0104; mem_addr_ok = 1;
      settle();
      total++;
      if (mem_req !== 1'b0 || inst_addr_ok !== 1'b0) begin
         bad++;
         $display("FAIL full_block: mem_req=%b inst_addr_ok=%b want 0 0", mem_req, inst_addr_ok);
      end
      tick();
      mem_data_ok = 1; mem_rdata = 32'h1111_2222;
      settle();
      total++;
      if (mem_req !== 1'b0 || inst_data_ok !== 1'b1) begin
         bad++;
         $display("FAIL full_pop: mem_req=%b inst_data_ok=%b want 0 1", mem_req, inst_data_ok);
      end
      tick();
      reset = 1; data_req = 1;
      settle();
      total++;
      if (out_vec() !== '0) begin
         bad++;
         $display("FAIL midflight_reset: got %h want all zero", out_vec());
      end
      tick();
      clear_inputs();
      reset = 0; mem_data_ok = 1;
      settle();
      total++;
      if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin
         bad++;
         $display("FAIL reset_abandon: inst_data_ok=%b data_data_ok=%b want 0 0",
                  inst_data_ok, data_data_ok);
      end
      tick();
      clear_inputs();
      inst_req = 1; inst_addr = 32'h1C00_0200; mem_addr_ok = 1;
      settle();
      total++;
      if (mem_req !== 1'b1 || inst_addr_ok !== 1'b1 || mem_addr !== 32'h1C00_0200) begin
         bad++;
         $display("FAIL post_reset_req: req=%b aok=%b addr=%h want 1 1 1c000200",
                  mem_req, inst_addr_ok, mem_addr);
      end
      tick();
      clear_inputs();
      mem_data_ok = 1; mem_rdata = 32'h3333_4444;
      settle();
      total++;
      if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h3333_4444) begin
         bad++;
         $display("FAIL post_reset_resp: inst_data_ok=%b rdata=%h want 1 33334444",
                  inst_data_ok, inst_rdata);
      end
      tick();
      clear_inputs();
   endtask

   task automatic test_random();
      ent_t         q[$];
      logic         h_v = 0, h_own = 0, h_disc = 0, last = OWN_DATA;
      logic [70:0]  h_cmd = '0, e_cmd;
      logic         e_req, e_own, acc, e_iaok, e_daok, e_idok, e_ddok;
      logic [139:0] want;
      do_reset();
      for (int c = 0; c < 500; c++) begin
         inst_req = ($urandom_range(0, 9) < 6); inst_addr = $urandom;
         data_req = ($urandom_range(0, 9) < 5); data_wr = 1'($urandom_range(0, 1));
         data_size = 2'($urandom_range(0, 2)); data_wstrb = 4'($urandom);
         data_addr = $urandom; data_wdata = $urandom;
         mem_addr_ok = ($urandom_range(0, 9) < 6);
         mem_data_ok = (q.size() > 0) && ($urandom_range(0, 1) == 1);
         mem_rdata = $urandom;
         flush = ($urandom_range(0, 9) == 0);

         e_req = 0; e_own = OWN_INST; e_cmd = '0;
         if (h_v) begin
            e_req = 1; e_own = h_own; e_cmd = h_cmd;
         end else if (q.size() < OUTST && (inst_req || data_req)) begin
            e_req = 1;
            if (inst_req && data_req) e_own = RR ? ~last : OWN_DATA;
            else                      e_own = data_req ? OWN_DATA : OWN_INST;
            e_cmd = (e_own == OWN_DATA) ? {data_wr, data_size, data_wstrb, data_addr, data_wdata}
                                        : {1'b0, 2'd2, 4'h0, inst_addr, 32'h0};
         end
         acc    = e_req && mem_addr_ok;
         e_iaok = acc && e_own == OWN_INST && !flush && !(h_v && h_disc);
         e_daok = acc && e_own == OWN_DATA;
         e_idok = mem_data_ok && q.size() > 0 && q[0].own == OWN_INST && !q[0].disc;
         e_ddok = mem_data_ok && q.size() > 0 && q[0].own == OWN_DATA;
         want   = {e_req, e_cmd, e_iaok, e_daok, e_idok, e_ddok, mem_rdata, mem_rdata};

         settle();
         total++;
         if (out_vec() !== want) begin
            bad++;
            $display("FAIL random_c%0d: got %h want %h", c, out_vec(), want);
         end

         if (mem_data_ok && q.size() > 0) q.delete(0);
         if (flush) foreach (q[i]) if (q[i].own == OWN_INST) q[i].disc = 1'b1;
         if (acc) q.push_back('{own: e_own, disc: (e_own == OWN_INST) && (flush || (h_v && h_disc))});
         if (acc) begin
            h_v = 0; h_disc = 0; last = e_own;
         end else if (e_req && !h_v) begin
            h_v = 1; h_own = e_own; h_cmd = e_cmd; h_disc = (e_own == OWN_INST) && flush;
         end else if (h_v && flush && h_own == OWN_INST) begin
            h_disc = 1;
         end
         tick();
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      reset = 1;
      #1;
      test_reset();
      test_lone_fetch();
      test_contention();
      test_lock();
      test_flush();
      test_full_and_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
